adc_serial_capture: RTL and testbench

- Front end between the external serial ADC pins and the recorder stage.
- On each trigger it runs one chip-select/serial-clock frame and shifts in the conversion word.
- It then presents the top data byte and a single-cycle end-of-conversion pulse that the recorder uses for its write enable and re-trigger.
- Trigger and end-of-conversion timing is defined so the recorder's back-to-back re-triggering always lands in IDLE.

---
 rtl/adc_pkg.sv | 18 +
 rtl/adc_serial_capture_if.sv | 31 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/adc_serial_capture.sv | 155 +++++++++++++++
 tb/tb_adc_serial_capture.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the serial ADC capture front end.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents: FSM state enum, default frame/data widths, output byte width.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    QUIET
  } state_t;

  localparam int FRAME_BITS_DEF = 16;
  localparam int DATA_BITS_DEF  = 12;
  localparam int BYTE_W         = 8;

endpackage

// File: rtl/adc_serial_capture_if.sv
// Bundle of ADC pin and recorder-side signals for adc_serial_capture.
// Latency: none (wiring only).
// Backpressure: none; the recorder paces itself off adc_eoc_out / adc_busy.
//
// master: the capture block (drives ADC pins and recorder outputs).
// slave : the environment (ADC data line and the recorder's trigger).
interface adc_serial_capture_if #(
  parameter int DATA_BITS = adc_pkg::DATA_BITS_DEF
);
  import adc_pkg::*;

  logic                 adc_trigger;
  logic                 adc_sdata;
  logic                 adc_cs_n;
  logic                 adc_sclk;
  logic [DATA_BITS-1:0] adc_sample;
  logic [BYTE_W-1:0]    adc_data;
  logic                 adc_eoc_out;
  logic                 adc_busy;

  modport master (
    input  adc_trigger, adc_sdata,
    output adc_cs_n, adc_sclk, adc_sample, adc_data, adc_eoc_out, adc_busy
  );

  modport slave (
    output adc_trigger, adc_sdata,
    input  adc_cs_n, adc_sclk, adc_sample, adc_data, adc_eoc_out, adc_busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Latency: 2 clk cycles.
// Backpressure: none.
//
// Ports: clk, rst_n (async, active-low, clears both stages), d (async in), q (synced out).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_serial_capture.sv
// Runs one cs_n/sclk frame per trigger, shifts in the ADC word, presents sample/byte with an eoc pulse.
// Latency: trigger to eoc = (2*FRAME_BITS+1)*CLK_DIV + QUIET_CYCLES cycles; sample/data update with eoc.
// Backpressure: triggers outside IDLE are dropped (or held as one pending request with ADC_TRIG_PENDING_EN).
//
// Ports: clk, rst_n (async, active-low); bus (master): adc_trigger, adc_sdata in;
//        adc_cs_n, adc_sclk, adc_sample, adc_data, adc_eoc_out, adc_busy out.
// Optional macro: ADC_TRIG_PENDING_EN (remember one trigger seen while busy).
module adc_serial_capture
  import adc_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int FRAME_BITS   = FRAME_BITS_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF,
  parameter int QUIET_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  adc_serial_capture_if.master bus
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int EW = $clog2(FRAME_BITS + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(FRAME_BITS);
  localparam logic [QW-1:0] Q_LAST    = QW'(QUIET_CYCLES - 1);

  state_t               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [EW-1:0]        edge_q, edge_d;
  logic [QW-1:0]        quiet_q, quiet_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] sample_q, sample_d;
  logic                 eoc_q, eoc_d;
  logic                 sdata_s;
  logic                 start_req;

  sync_2ff #(.WIDTH(1)) u_sdata_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.adc_sdata),
    .q     (sdata_s)
  );

`ifdef ADC_TRIG_PENDING_EN
  logic pend_q, pend_d;

  // One remembered request; it is consumed in the IDLE cycle where it launches the frame.
  always_comb begin
    pend_d = pend_q;
    if (state_q == IDLE)      pend_d = 1'b0;
    else if (bus.adc_trigger) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end

  assign start_req = bus.adc_trigger | pend_q;
`else
  assign start_req = bus.adc_trigger;
`endif

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    edge_d   = edge_q;
    quiet_d  = quiet_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    shift_d  = shift_q;
    sample_d = sample_q;
    eoc_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = FRAME;
          cs_n_d  = 1'b0;
          div_d   = '0;
          edge_d  = '0;
        end
      end
      FRAME: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          // After the last rising edge sclk has already been high for one
          // half period here: close the frame instead of toggling again.
          if (sclk_q && edge_q == EDGE_LAST) begin
            state_d = QUIET;
            cs_n_d  = 1'b1;
            quiet_d = '0;
          end else begin
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              // Only the trailing DATA_BITS bits are ever presented, so
              // leading frame bits simply fall off the top.
              shift_d = {shift_q[DATA_BITS-2:0], sdata_s};
              edge_d  = edge_q + EW'(1);
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      QUIET: begin
        if (quiet_q == Q_LAST) state_d = IDLE;
        else                   quiet_d = quiet_q + QW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Registered so the pulse and new data are both visible during the last QUIET cycle.
    if (state_d == QUIET && quiet_d == Q_LAST) begin
      eoc_d    = 1'b1;
      sample_d = shift_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      edge_q   <= '0;
      quiet_q  <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      shift_q  <= '0;
      sample_q <= '0;
      eoc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      edge_q   <= edge_d;
      quiet_q  <= quiet_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      eoc_q    <= eoc_d;
    end
  end

  assign bus.adc_cs_n    = cs_n_q;
  assign bus.adc_sclk    = sclk_q;
  assign bus.adc_sample  = sample_q;
  assign bus.adc_data    = sample_q[DATA_BITS-1 -: BYTE_W];
  assign bus.adc_eoc_out = eoc_q;
  assign bus.adc_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture: two instances (defaults, and CLK_DIV=3/QUIET_CYCLES=1),
// a serial ADC model per instance, a timing model checked every cycle, and directed literal checks.
module tb_adc_serial_capture;
  import adc_pkg::*;

`ifdef ADC_TRIG_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        trig [2] = '{1'b0, 1'b0};
  logic [15:0] word [2] = '{16'h0, 16'h0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int D = (g == 0) ? 4 : 3;
    localparam int Q = (g == 0) ? 2 : 1;
    localparam int L = (2 * FRAME_BITS_DEF + 1) * D;

    adc_serial_capture_if #(.DATA_BITS(DATA_BITS_DEF)) bus ();

    adc_serial_capture #(
      .CLK_DIV(D), .FRAME_BITS(FRAME_BITS_DEF), .DATA_BITS(DATA_BITS_DEF), .QUIET_CYCLES(Q)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
    );

    assign bus.adc_trigger = trig[g];

    // ADC: latches the word at cs_n fall, presents one bit per sclk falling edge, MSB first.
    logic        sd = 1'b0;
    logic [15:0] aw = 16'h0;
    int          ai = -1;
    assign bus.adc_sdata = sd;
    always @(negedge bus.adc_sclk or negedge bus.adc_cs_n) begin
      if (!bus.adc_cs_n && bus.adc_sclk) begin
        aw = word[g];
        ai = 15;
        sd = 1'b0;
      end else if (!bus.adc_cs_n && ai >= 0) begin
        sd = aw[ai];
        ai--;
      end
    end

    // Timing model: a frame is a window of L cs_n-low cycles followed by Q quiet cycles,
    // and any cycle outside that window is idle and may launch the next frame.
    longint      cyc = 0;
    longint      st = 0;
    bit          act = 1'b0;
    bit          pend = 1'b0;
    bit          was_busy = 1'b0;
    logic [15:0] fw = 16'h0;
    logic [11:0] ms = 12'h0;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cyc = 0; act = 1'b0; pend = 1'b0; ms = 12'h0;
      end else begin
        was_busy = act && (cyc - st) < L + Q;
        cyc++;
        if (!was_busy && (trig[g] || pend)) begin
          act = 1'b1; st = cyc; fw = word[g]; pend = 1'b0;
        end else if (was_busy && trig[g] && PEND_EN) begin
          pend = 1'b1;
        end
        if (act && (cyc - st) == L + Q - 1) ms = fw[11:0];
      end
    end

    longint t;
    always @(negedge clk) begin
      t = act ? (cyc - st) : -1000;
      check($sformatf("u%0d.cs_n", g), bus.adc_cs_n, !(t >= 0 && t < L));
      check($sformatf("u%0d.sclk", g), bus.adc_sclk, !(t >= 0 && t < L && ((t / D) % 2) == 1));
      check($sformatf("u%0d.busy", g), bus.adc_busy, (t >= 0 && t < L + Q));
      check($sformatf("u%0d.eoc", g), bus.adc_eoc_out, (t == L + Q - 1));
      check($sformatf("u%0d.sample", g), bus.adc_sample, ms);
      check($sformatf("u%0d.data", g), bus.adc_data, ms[11:4]);
    end

    // Measurements used by the directed literal checks.
    longint nc = 0, start = 0, prev_start = 0;
    int     len = 0, rises = 0, since_hi = 0, eocs = 0, frames = 0, eoc_ofs = 0;
    int     last_len = 0, last_rises = 0;
    logic   p_cs = 1'b1, p_sclk = 1'b1;
    always @(negedge clk) begin
      nc++;
      if (!bus.adc_cs_n) begin
        if (p_cs) begin
          prev_start = start; start = nc; len = 0; rises = 0; frames++;
        end
        len++;
        if (bus.adc_sclk && !p_sclk) rises++;
        since_hi = 0;
      end else begin
        if (!p_cs) begin last_len = len; last_rises = rises; end
        since_hi++;
      end
      if (bus.adc_eoc_out) begin eocs++; eoc_ofs = since_hi; end
      p_cs = bus.adc_cs_n;
      p_sclk = bus.adc_sclk;
    end
  end

  task automatic pulse(input int g);
    @(negedge clk);
    trig[g] = 1'b1;
    @(negedge clk);
    trig[g] = 1'b0;
  endtask

  logic [15:0] rw [4] = '{16'h0FFF, 16'h0000, 16'h0800, 16'h0123};
  logic [7:0]  rb [4] = '{8'hFF, 8'h00, 8'h80, 8'h12};

  initial begin
    int     k;
    int     e0, f0;
    longint s0;

    // Reset and idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_cs_n", u[0].bus.adc_cs_n, 1'b1);
    check("rst_sclk", u[0].bus.adc_sclk, 1'b1);
    check("rst_busy", u[0].bus.adc_busy, 1'b0);
    check("rst_data", u[0].bus.adc_data, 8'h00);
    check("rst_eocs", u[0].eocs, 0);

    // Single frame with defaults.
    word[0] = 16'h0A5C;
    pulse(0);
    repeat (140) @(negedge clk);
    check("single_cs_len", u[0].last_len, 132);
    check("single_rises", u[0].last_rises, 16);
    check("single_eocs", u[0].eocs, 1);
    check("single_eoc_ofs", u[0].eoc_ofs, 2);
    check("single_sample", u[0].bus.adc_sample, 12'hA5C);
    check("single_data", u[0].bus.adc_data, 8'hA5);

    // Recorder-style re-trigger in the cycle after each eoc.
    word[0] = rw[0];
    pulse(0);
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (u[0].bus.adc_eoc_out !== 1'b1 && k < 300) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("retrig%0d_eoc_seen", i), (k < 300), 1'b1);
      check($sformatf("retrig%0d_data", i), u[0].bus.adc_data, rb[i]);
      if (i > 0) check($sformatf("retrig%0d_spacing", i), u[0].start - u[0].prev_start, 135);
      @(negedge clk);
      if (i < 3) begin
        word[0] = rw[i+1];
        trig[0] = 1'b1;
      end
      @(negedge clk);
      trig[0] = 1'b0;
    end
    repeat (5) @(negedge clk);

    // Trigger arriving mid-frame.
    f0 = u[0].frames;
    word[0] = 16'h0321;
    pulse(0);
    repeat (5) @(negedge clk);
    s0 = u[0].start;
    repeat (44) @(negedge clk);
    pulse(0);
    repeat (300) @(negedge clk);
    check("busy_frames", u[0].frames - f0, PEND_EN ? 2 : 1);
    check("busy_second_start", u[0].start - s0, PEND_EN ? 135 : 0);
    check("busy_data", u[0].bus.adc_data, 8'h32);

    // Reset in the middle of a frame.
    word[0] = 16'h0ABC;
    pulse(0);
    repeat (69) @(negedge clk);
    e0 = u[0].eocs;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs_n", u[0].bus.adc_cs_n, 1'b1);
    check("midrst_sclk", u[0].bus.adc_sclk, 1'b1);
    check("midrst_busy", u[0].bus.adc_busy, 1'b0);
    check("midrst_data", u[0].bus.adc_data, 8'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_eoc", u[0].eocs - e0, 0);
    word[0] = 16'h0C3F;
    pulse(0);
    repeat (140) @(negedge clk);
    check("postrst_data", u[0].bus.adc_data, 8'hC3);
    check("postrst_cs_len", u[0].last_len, 132);
    check("postrst_eocs", u[0].eocs - e0, 1);

    // Divider corner on the second instance.
    word[1] = 16'h0FFF;
    pulse(1);
    repeat (110) @(negedge clk);
    check("div3_cs_len", u[1].last_len, 99);
    check("div3_rises", u[1].last_rises, 16);
    check("div3_data", u[1].bus.adc_data, 8'hFF);
    check("div3_eoc_ofs", u[1].eoc_ofs, 1);
    check("div3_eocs", u[1].eocs, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
